// File: rtl/cache_ctrl_param.sv
// rtl/cache_ctrl_param.sv - direct-mapped write-back write-allocate cache controller
//
// Purpose: one-word-per-line direct-mapped cache between a CPU request port
// and a backing memory. A miss on a dirty line first writes the victim back,
// then refills the line and re-runs the lookup, which then hits.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   cpu_req, R_W          CPU request (held until ready), 1 = write
//   address, data         CPU word address and write data
//   out, ready            read data and one-cycle completion pulse
//   mem_req, mem_we       memory request (held until mem_ack), 1 = write-back
//   mem_addr, mem_wdata   memory word address and write-back data
//   mem_rdata, mem_ack    refill data and one-cycle memory completion
//   hit_count, miss_count saturating lookup statistics
module cache_ctrl_param #(
  parameter int DATA_W  = 10,
  parameter int ADDR_W  = 10,
  parameter int INDEX_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              R_W,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] out,
  output logic              ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    REFILL,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [LINES-1:0]  valid;
  logic [LINES-1:0]  dirty;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              req_rw;
  // Set once the refill lands so the follow-up lookup is not counted again.
  logic              relookup;

  logic [INDEX_W-1:0] req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               hit;

  assign req_idx = req_addr[INDEX_W-1:0];
  assign req_tag = req_addr[ADDR_W-1:INDEX_W];
  assign hit     = valid[req_idx] && (tag_mem[req_idx] == req_tag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Memory-side outputs come straight from the state and from line contents
  // that are not touched until mem_ack, so they hold steady for the whole
  // request and fall to zero the moment reset forces IDLE.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          state_nxt = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          state_nxt = RESP;
        end else if (dirty[req_idx]) begin
          state_nxt = WRITEBACK;
        end else begin
          state_nxt = REFILL;
        end
      end
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_mem[req_idx], req_idx};
        mem_wdata = data_mem[req_idx];
        if (mem_ack) begin
          state_nxt = REFILL;
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = req_addr;
        if (mem_ack) begin
          state_nxt = LOOKUP;
        end
      end
      RESP: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid      <= '0;
      dirty      <= '0;
      req_addr   <= '0;
      req_data   <= '0;
      req_rw     <= 1'b0;
      relookup   <= 1'b0;
      out        <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_mem[i]  <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            req_addr <= address;
            req_data <= data;
            req_rw   <= R_W;
            relookup <= 1'b0;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (req_rw) begin
              data_mem[req_idx] <= req_data;
              dirty[req_idx]    <= 1'b1;
            end else begin
              out <= data_mem[req_idx];
            end
          end
          if (!relookup) begin
            if (hit) begin
              if (hit_count != {CNT_W{1'b1}}) begin
                hit_count <= hit_count + 1'b1;
              end
            end else begin
              if (miss_count != {CNT_W{1'b1}}) begin
                miss_count <= miss_count + 1'b1;
              end
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            dirty[req_idx] <= 1'b0;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            data_mem[req_idx] <= mem_rdata;
            tag_mem[req_idx]  <= req_tag;
            valid[req_idx]    <= 1'b1;
            dirty[req_idx]    <= 1'b0;
            relookup          <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl_param.sv
// tb/tb_cache_ctrl_param.sv - scoreboard testbench for cache_ctrl_param
module tb_cache_ctrl_param;

  localparam int DW    = 10;
  localparam int AW    = 10;
  localparam int IW    = 4;
  localparam int CW    = 4;
  localparam int LINES = 1 << IW;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req;
  logic          R_W;
  logic [AW-1:0] address;
  logic [DW-1:0] data;
  logic [DW-1:0] out;
  logic          ready;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;

  cache_ctrl_param #(.DATA_W(DW), .ADDR_W(AW), .INDEX_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .R_W(R_W), .address(address),
    .data(data), .out(out), .ready(ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Backing memory (responder side) and the reference copy the model keeps.
  logic [DW-1:0] mem     [1 << AW];
  logic [DW-1:0] ref_mem [1 << AW];

  // Reference cache model.
  bit            m_valid [LINES];
  bit            m_dirty [LINES];
  logic [AW-IW-1:0] m_tag [LINES];
  logic [DW-1:0] m_data  [LINES];
  int            exp_hits;
  int            exp_miss;
  logic [DW-1:0] exp_out;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  txn_t          txn_q[$];
  logic [DW-1:0] out_q[$];

  int ack_delay;
  bit stray_en;

  function automatic void model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    exp_hits = 0;
    exp_miss = 0;
    exp_out  = '0;
    txn_q.delete();
    out_q.delete();
  endfunction

  // Predicts one request: memory traffic, line update, counters, out.
  function automatic bit model_req(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [IW-1:0]    idx;
    logic [AW-IW-1:0] tg;
    bit               h;
    txn_t             t;
    idx = a[IW-1:0];
    tg  = a[AW-1:IW];
    h   = m_valid[idx] && (m_tag[idx] == tg);
    if (h) begin
      if (exp_hits < CMAX) exp_hits++;
    end else begin
      if (exp_miss < CMAX) exp_miss++;
      if (m_valid[idx] && m_dirty[idx]) begin
        t.we    = 1'b1;
        t.addr  = {m_tag[idx], idx};
        t.wdata = m_data[idx];
        txn_q.push_back(t);
        ref_mem[t.addr] = t.wdata;
      end
      t.we    = 1'b0;
      t.addr  = a;
      t.wdata = '0;
      txn_q.push_back(t);
      m_valid[idx] = 1;
      m_dirty[idx] = 0;
      m_tag[idx]   = tg;
      m_data[idx]  = ref_mem[a];
    end
    if (rw) begin
      m_data[idx]  = d;
      m_dirty[idx] = 1;
    end else begin
      exp_out = m_data[idx];
    end
    return h;
  endfunction

  // Memory responder: acks after ack_delay cycles, checks request stability
  // and the expected transaction order, and throws stray acks while idle.
  initial begin
    int            wait_cnt;
    bit            in_txn;
    logic [20:0]   snap;
    txn_t          t;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    wait_cnt  = 0;
    in_txn    = 0;
    snap      = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (rst) begin
        in_txn   = 0;
        wait_cnt = 0;
      end else if (mem_req) begin
        if (!in_txn) begin
          snap     = {mem_we, mem_addr, mem_wdata};
          in_txn   = 1;
          wait_cnt = 0;
        end else begin
          check("mem_stable", {11'd0, mem_we, mem_addr, mem_wdata}, {11'd0, snap});
        end
        if (wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          if (mem_we) mem[mem_addr] = mem_wdata;
          if (txn_q.size() == 0) begin
            check("mem_txn_unexpected", 32'd1, 32'd0);
          end else begin
            t = txn_q.pop_front();
            check("mem_we", {31'd0, mem_we}, {31'd0, t.we});
            check("mem_addr", {22'd0, mem_addr}, {22'd0, t.addr});
            if (t.we) check("mem_wdata", {22'd0, mem_wdata}, {22'd0, t.wdata});
          end
          in_txn = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        in_txn = 0;
        if (stray_en) begin
          mem_ack   = 1'($urandom_range(0, 1));
          mem_rdata = DW'($urandom);
        end
      end
    end
  end

  task automatic do_req(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit            h;
    bit            got;
    int            cyc;
    logic [DW-1:0] e;
    h = model_req(rw, a, d);
    out_q.push_back(exp_out);
    @(negedge clk);
    cpu_req = 1'b1;
    R_W     = rw;
    address = a;
    data    = d;
    @(posedge clk);
    cyc = 0;
    got = 0;
    while (cyc < 200 && !got) begin
      @(negedge clk);
      cyc++;
      if (ready) got = 1;
    end
    cpu_req = 1'b0;
    if (!got) begin
      check("ready_timeout", 32'd0, 32'd1);
    end else begin
      if (h) check("hit_latency", cyc, 32'd2);
      e = out_q.pop_front();
      check(rw ? "out_on_write" : "out_on_read", {22'd0, out}, {22'd0, e});
      check("hit_count", {28'd0, hit_count}, exp_hits);
      check("miss_count", {28'd0, miss_count}, exp_miss);
      @(negedge clk);
      check("ready_one_cycle", {31'd0, ready}, 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, ready}, 32'd0);
    check({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_out"}, {22'd0, out}, 32'd0);
    check({tag, "_mem_addr"}, {22'd0, mem_addr}, 32'd0);
    check({tag, "_mem_wdata"}, {22'd0, mem_wdata}, 32'd0);
    check({tag, "_hit_count"}, {28'd0, hit_count}, 32'd0);
    check({tag, "_miss_count"}, {28'd0, miss_count}, 32'd0);
  endtask

  initial begin
    bit h;
    int cyc;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = DW'(i * 37 + 11);
      ref_mem[i] = DW'(i * 37 + 11);
    end
    rst       = 1'b1;
    cpu_req   = 1'b0;
    R_W       = 1'b0;
    address   = '0;
    data      = '0;
    ack_delay = 0;
    stray_en  = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Write miss then read hit on line 2.
    do_req(1'b1, 10'h002, 10'h0C3);
    do_req(1'b0, 10'h002, 10'h000);
    check("read_002", {22'd0, out}, 32'h0C3);

    // Dirty victim on index 5 forces write-back before the refill.
    ack_delay = 1;
    do_req(1'b1, 10'h2A5, 10'h025);
    do_req(1'b0, 10'h0A5, 10'h000);
    check("read_0a5", {22'd0, out}, {22'd0, 10'(10'h0A5 * 37 + 11)});

    // Long memory latency with stray acks while idle.
    ack_delay = 7;
    stray_en  = 1;
    do_req(1'b1, 10'h0A5, 10'h1F0);
    do_req(1'b0, 10'h1B5, 10'h000);
    do_req(1'b0, 10'h0A5, 10'h000);

    // Random mix over four tags and four indices.
    for (int n = 0; n < 40; n++) begin
      ack_delay = $urandom_range(0, 3);
      do_req(1'($urandom_range(0, 1)),
             {6'($urandom_range(0, 3)), 4'($urandom_range(0, 3))},
             DW'($urandom));
    end
    check("txn_q_drained", txn_q.size(), 32'd0);

    // Reset in the middle of a refill.
    ack_delay = 7;
    stray_en  = 0;
    h = model_req(1'b0, 10'h3C7, 10'h000);
    @(negedge clk);
    cpu_req = 1'b1;
    R_W     = 1'b0;
    address = 10'h3C7;
    cyc     = 0;
    while (cyc < 100 && !(mem_req && !mem_we)) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_refill", {31'd0, mem_req && !mem_we}, 32'd1);
    @(negedge clk);
    rst     = 1'b1;
    cpu_req = 1'b0;
    #1;
    check_reset_outputs("mid_refill_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    ack_delay = 2;
    do_req(1'b0, 10'h3C7, 10'h000);
    check("post_reset_miss", {28'd0, miss_count}, 32'd1);
    check("post_reset_read", {22'd0, out}, {22'd0, ref_mem[10'h3C7]});

    // Saturating hit counter.
    for (int n = 0; n < 20; n++) begin
      do_req(1'b0, 10'h3C7, 10'h000);
    end
    check("hit_saturated", {28'd0, hit_count}, 32'hF);
    check("txn_q_final", txn_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_ctrl_param.md
CACHE_CTRL_PARAM -- requirements
Module: cache_ctrl_param

Interface
REQ-001 Parameters SHALL be: DATA_W, default 10, word width; ADDR_W, default 10, word address width; INDEX_W, default 4, line index width (2^INDEX_W lines, one word per line); CNT_W, default 16, statistics counter width.
REQ-002 TAG_W SHALL be derived as ADDR_W-INDEX_W; configurations with INDEX_W >= ADDR_W are illegal.
REQ-003 One clock; reset is asynchronous and active-high (ports clk, rst).
REQ-004 Ports SHALL be:
  clk        in   1        clock, all state updates on rising edge
  rst        in   1        asynchronous active-high reset
  cpu_req    in   1        CPU request, held high until ready seen
  R_W        in   1        1 = write, 0 = read
  address    in   ADDR_W   CPU word address
  data       in   DATA_W   CPU write data
  out        out  DATA_W   read data, valid while ready=1 on a read
  ready      out  1        one-cycle completion pulse
  mem_req    out  1        backing-memory request, held until mem_ack
  mem_we     out  1        1 = memory write (write-back), 0 = refill read
  mem_addr   out  ADDR_W   memory word address
  mem_wdata  out  DATA_W   write-back data
  mem_rdata  in   DATA_W   refill data, valid with mem_ack
  mem_ack    in   1        memory completion, one cycle
  hit_count  out  CNT_W    lookups that hit
  miss_count out  CNT_W    lookups that missed

Function
REQ-005 Organisation SHALL be direct-mapped, write-back, write-allocate; index = address[INDEX_W-1:0], tag = address[ADDR_W-1:INDEX_W]; each line holds valid, dirty, tag, data.
REQ-006 FSM states SHALL be IDLE, LOOKUP, WRITEBACK, REFILL, RESP.
REQ-007 IDLE: cpu_req=1 at a rising edge SHALL latch address, data, R_W and move to LOOKUP; cpu_req in any other state SHALL be ignored.
REQ-008 LOOKUP hit (valid and tag match): read SHALL load out with line data; write SHALL store latched data and set dirty; next state RESP.
REQ-009 LOOKUP miss with dirty victim SHALL go to WRITEBACK; miss with clean or invalid victim SHALL go to REFILL.
REQ-010 WRITEBACK SHALL drive mem_req=1, mem_we=1, mem_addr={victim tag, index}, mem_wdata=victim data; on mem_ack clear dirty and go to REFILL.
REQ-011 REFILL SHALL drive mem_req=1, mem_we=0, mem_addr=latched address; on mem_ack write mem_rdata into line, set valid, clear dirty, store tag, return to LOOKUP (which then hits).
REQ-012 RESP SHALL assert ready=1 for exactly one cycle, then go to IDLE; hit latency is 2 cycles from the accepting edge to ready.
REQ-013 mem_req, mem_we, mem_addr, mem_wdata SHALL be stable while mem_req=1; mem_ack while mem_req=0 SHALL be ignored.
REQ-014 out SHALL hold its last value outside read completion; on a write completion out SHALL be unchanged.
REQ-015 hit_count/miss_count SHALL increment once per original lookup only (the post-refill re-lookup counts as neither) and saturate at all-ones.

Reset
REQ-016 rst=1 SHALL immediately force IDLE, clear all valid and dirty bits, ready=0, mem_req=0, mem_we=0, out=0, mem_addr=0, mem_wdata=0, hit_count=0, miss_count=0, including mid WRITEBACK/REFILL; no partial line update SHALL remain.

Verification
REQ-017 After reset, write 0x002 <- 0x0C3 -> miss_count=1, REFILL at mem_addr 0x002, ready pulse, line 2 dirty; then read 0x002 -> hit, out=0x0C3, ready 2 cycles after accept, hit_count=1.
REQ-018 Write 0x2A5 <- 0x025, then read 0x0A5 (same index 5) -> WRITEBACK mem_we=1 mem_addr=0x2A5 mem_wdata=0x025, then REFILL mem_addr=0x0A5, out=mem_rdata.
REQ-019 Delay mem_ack 0, 1 and 7 cycles -> memory outputs stable throughout, exactly one ready per request.
REQ-020 Assert rst during REFILL -> outputs at reset values within the cycle, subsequent read of same address misses.
REQ-021 Drive CNT_W=4 with 20 hits -> hit_count saturates at 0xF.
